muldiv_iter: RTL and testbench

- Iterative RV32M multiply/divide unit.
- Sits directly downstream of the register file read ports (rs1/rs2 data) and upstream of its write port.
- Takes one operation per start pulse and produces a single-cycle write-back beat (wb_en/wb_addr/result) for the register file.
- Uses fixed-latency radix-2 shift-add multiply and restoring divide, with one shared 64-bit accumulator.

---
 rtl/muldiv_iter_pkg.sv | 24 ++
 rtl/muldiv_iter.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_iter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_iter_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state codes and special result values.
package muldiv_iter_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [MD_XLEN-1:0] QUOT_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [MD_XLEN-1:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M mul/div: radix-2 shift-add multiply, restoring divide, shared 64-bit accumulator.
// Latency: start at edge E0 -> one-cycle done/wb_en pulse after edge E0+33, for every op.
// Backpressure: none; start is only accepted in IDLE, requests while busy are dropped.
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wb_addr,
    output logic            wb_en
);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   a_raw_q, a_raw_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic              b_zero_q, b_zero_d;
    logic              ovf_q, ovf_d;
    logic [XLEN-1:0]   result_q, result_d;

    function automatic logic [2*XLEN-1:0] cneg_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Operand preparation for the start edge
    logic            in_sign_a, in_sign_b;
    logic [XLEN-1:0] in_abs_a, in_abs_b;

    assign in_sign_a = ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM))
                       && rs1_data[XLEN-1];
    assign in_sign_b = ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM)) && rs2_data[XLEN-1];
    assign in_abs_a  = cneg(rs1_data, in_sign_a);
    assign in_abs_b  = cneg(rs2_data, in_sign_b);

    // Multiply step: conditional add into the upper half, then shift right with the carry.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide step: the partial remainder stays below the divisor, so the shifted value fits in XLEN+1 bits.
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] div_next;

    assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    assign div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    logic [2*XLEN-1:0] fix_prod;
    logic [XLEN-1:0]   fix_quot, fix_rem;

    always_comb begin
        fix_prod = cneg_wide(acc_q, sign_a_q ^ sign_b_q);
        fix_quot = cneg(acc_q[XLEN-1:0], sign_a_q ^ sign_b_q);
        fix_rem  = cneg(acc_q[2*XLEN-1:XLEN], sign_a_q);
        if (b_zero_q) begin
            fix_quot = QUOT_ALL_ONES;
            fix_rem  = a_raw_q;
        end else if (ovf_q) begin
            fix_quot = INT_MIN;
            fix_rem  = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        op_d      = op_q;
        wb_addr_d = wb_addr_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        b_zero_d  = b_zero_q;
        ovf_d     = ovf_q;
        result_d  = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = op;
                    wb_addr_d = rd_addr;
                    sign_a_d  = in_sign_a;
                    sign_b_d  = in_sign_b;
                    a_raw_d   = rs1_data;
                    b_zero_d  = (rs2_data == '0);
                    ovf_d     = ((op == OP_DIV) || (op == OP_REM))
                                && (rs1_data == INT_MIN) && (rs2_data == QUOT_ALL_ONES);
                    cnt_d     = '0;
                    if (op[2]) begin
                        acc_d  = {{XLEN{1'b0}}, in_abs_a};
                        opnd_d = in_abs_b;
                    end else begin
                        acc_d  = {{XLEN{1'b0}}, in_abs_b};
                        opnd_d = in_abs_a;
                    end
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                case (op_q)
                    OP_MUL:                        result_d = fix_prod[XLEN-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU:  result_d = fix_prod[2*XLEN-1:XLEN];
                    OP_DIV, OP_DIVU:               result_d = fix_quot;
                    default:                       result_d = fix_rem;
                endcase
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            op_q      <= '0;
            wb_addr_q <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            b_zero_q  <= 1'b0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            op_q      <= op_d;
            wb_addr_q <= wb_addr_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            b_zero_q  <= b_zero_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign result  = result_q;
    assign wb_addr = wb_addr_q;
    assign wb_en   = done && (wb_addr_q != 5'd0);

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: directed corner cases plus random ops against an arithmetic reference.
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_addr = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  wb_addr;
    logic        wb_en;

    int checks = 0;
    int errors = 0;

    muldiv_iter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_addr  (rd_addr),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .wb_addr  (wb_addr),
        .wb_en    (wb_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              ia, ib;
        ia = $signed(a);
        ib = $signed(b);
        sa = longint'(ia);
        sb = longint'(ib);
        ua = 64'(a);
        ub = 64'(b);
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Issue one op at edge E0 and watch edges E0+1..E0+37.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input bit inject);
        int          done_at = 0;
        int          pulses = 0;
        int          wb_pulses = 0;
        int          busy_bad = 0;
        logic [31:0] res_at = '0;
        logic [4:0]  addr_at = '0;
        logic        wb_at = 1'b0;
        @(negedge clk);
        start = 1'b1; op = f; rs1_data = a; rs2_data = b; rd_addr = rd;
        @(posedge clk); #1;
        start = 1'b0;
        op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_addr = 5'($urandom);
        if (busy !== 1'b1) busy_bad++;
        for (int k = 1; k <= 37; k++) begin
            start = inject && (k == 5 || k == 33 || k == 34);
            if (start) begin
                op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_addr = 5'($urandom_range(1, 31));
            end
            @(posedge clk); #1;
            if (done === 1'b1) begin
                pulses++;
                if (done_at == 0) begin
                    done_at = k;
                    res_at  = result;
                    addr_at = wb_addr;
                    wb_at   = wb_en;
                end
            end
            if (wb_en === 1'b1) wb_pulses++;
            if ((k <= 33) != (busy === 1'b1)) busy_bad++;
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, 64'(done_at), 64'd33);
        chk({tag, "_done_pulses"}, 64'(pulses), 64'd1);
        chk({tag, "_result"}, 64'(res_at), 64'(exp));
        chk({tag, "_wb_addr"}, 64'(addr_at), 64'(rd));
        chk({tag, "_wb_en"}, 64'(wb_at), 64'(rd != 5'd0));
        chk({tag, "_wb_pulses"}, 64'(wb_pulses), 64'(rd != 5'd0));
        chk({tag, "_busy_window"}, 64'(busy_bad), 64'd0);
        chk({tag, "_result_hold"}, 64'(result), 64'(exp));
    endtask

    initial begin
        int          quiet_done;
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        int          sel;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_wb_en", 64'(wb_en), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_wb_addr", 64'(wb_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 1'b0);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 1'b0);
        run_op("mulhu_ones", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 1'b0);
        run_op("mulhsu_ones", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, 1'b0);
        run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 1'b0);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd10, 32'd2, 1'b0);
        run_op("divu_by0", 3'd5, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1'b0);
        run_op("div_by0", 3'd4, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1'b0);
        run_op("rem_by0", 3'd6, 32'd5, 32'd0, 5'd13, 32'd5, 1'b0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1'b0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1'b0);
        run_op("start_busy", 3'd0, 32'd1234, 32'd5678, 5'd16, 32'd7006652, 1'b1);
        run_op("rd_zero", 3'd5, 32'd81, 32'd9, 5'd0, 32'd9, 1'b0);

        // Reset during CALC must abort without any completion.
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs1_data = 32'd77; rs2_data = 32'd3; rd_addr = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_wb_addr", 64'(wb_addr), 64'd0);
        rst_n = 1'b1;
        quiet_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || wb_en === 1'b1 || busy === 1'b1) quiet_done++;
        end
        chk("abort_quiet", 64'(quiet_done), 64'd0);
        run_op("post_rst_mulhu", 3'd3, 32'd3, 32'd5, 5'd21, 32'd0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rf  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 7);
            ra  = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'd0 : $urandom;
            rb  = (sel == 2) ? 32'd0 : (sel == 3) ? 32'hFFFF_FFFF : (sel == 4) ? 32'd1
                : (sel == 5) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_op($sformatf("rand%0d_op%0d", i, rf), rf, ra, rb, 5'($urandom), ref_res(rf, ra, rb), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
